bus_rr_arbiter: RTL and testbench

- Shares one simple slave bus (req/ack handshake, 32-bit addr/data) between mst_c masters.
- Round-robin arbitration; one transaction in flight at a time.
- Drives a one-hot owner vector `grant` that steers return data to the winning master, using the same one-hot select convention as the slave read-data mux.
- Runs a per-transaction ack timeout so a dead slave cannot hang the bus.
- Sits between the masters (CPU, DMA) and the address decoder / read-data mux.

---
 rtl/bus_rr_arbiter.sv | 174 +++++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin owner of a single req/ack slave bus.
// One transaction in flight, registered outputs, per-transaction ack timeout.
module bus_rr_arbiter #(
   parameter int mst_c = 2,
   parameter int tmo_c = 255
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [mst_c-1:0]      req_m,
   input  logic [mst_c-1:0]      we_m,
   input  logic [mst_c*32-1:0]   addr_m,
   input  logic [mst_c*32-1:0]   wd_m,
   output logic [mst_c-1:0]      ack_m,
   output logic [mst_c-1:0]      err_m,
   output logic [31:0]           rd_m,
   output logic [mst_c-1:0]      grant,
   output logic                  req,
   output logic                  we,
   output logic [31:0]           addr,
   output logic [31:0]           wd,
   input  logic                  ack,
   input  logic [31:0]           rd
);

   localparam int iw = (mst_c > 1) ? $clog2(mst_c) : 1;
   localparam int cb = $clog2(tmo_c + 1);
   localparam int cw = (cb > 8) ? cb : 8;

   localparam logic [cw-1:0] tmo_last =
      (tmo_c == 0) ? '0 : cw'(tmo_c - 1);
   localparam logic [iw-1:0] owner_rst = iw'(mst_c - 1);
   localparam logic [mst_c-1:0] one_hot0 =
      {{(mst_c-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t state;
   state_t state_n;

   logic [iw-1:0]    last;
   logic [iw-1:0]    last_n;
   logic [cw-1:0]    cnt;
   logic [cw-1:0]    cnt_n;

   logic [mst_c-1:0] ack_m_n;
   logic [mst_c-1:0] err_m_n;
   logic [31:0]      rd_m_n;
   logic [mst_c-1:0] grant_n;
   logic             req_n;
   logic             we_n;
   logic [31:0]      addr_n;
   logic [31:0]      wd_n;

   logic             found;
   logic [iw-1:0]    win;
   logic [iw-1:0]    cand;
   logic             tmo_hit;

   // Round-robin search: first requester above the last owner, wrapping.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int i = 1; i <= mst_c; i++) begin
         cand = iw'((int'(last) + i) % mst_c);
         if (!found && req_m[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // Timeout fires on the last allowed BUSY cycle; disabled when tmo_c is 0.
   always_comb begin
      tmo_hit = (tmo_c != 0) && (cnt == tmo_last);
   end

   // Next state and next values of every registered output.
   always_comb begin
      state_n = state;
      last_n  = last;
      cnt_n   = cnt;
      ack_m_n = '0;
      err_m_n = '0;
      rd_m_n  = rd_m;
      grant_n = grant;
      req_n   = req;
      we_n    = we;
      addr_n  = addr;
      wd_n    = wd;
      unique case (state)
         IDLE: begin
            grant_n = '0;
            req_n   = 1'b0;
            if (found) begin
               state_n = BUSY;
               last_n  = win;
               cnt_n   = '0;
               grant_n = one_hot0 << win;
               req_n   = 1'b1;
               we_n    = we_m[win];
               addr_n  = addr_m[int'(win)*32 +: 32];
               wd_n    = wd_m[int'(win)*32 +: 32];
            end
         end
         BUSY: begin
            if (ack) begin
               state_n = DONE;
               req_n   = 1'b0;
               rd_m_n  = rd;
               ack_m_n = grant;
            end else if (tmo_hit) begin
               state_n = DONE;
               req_n   = 1'b0;
               rd_m_n  = '0;
               err_m_n = grant;
            end else begin
               cnt_n = cnt + cw'(1);
            end
         end
         DONE: begin
            state_n = IDLE;
            grant_n = '0;
            req_n   = 1'b0;
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
            req_n   = 1'b0;
         end
      endcase
   end

   // State register; reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Output, owner and timeout registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         last  <= owner_rst;
         cnt   <= '0;
         ack_m <= '0;
         err_m <= '0;
         rd_m  <= '0;
         grant <= '0;
         req   <= 1'b0;
         we    <= 1'b0;
         addr  <= '0;
         wd    <= '0;
      end else begin
         last  <= last_n;
         cnt   <= cnt_n;
         ack_m <= ack_m_n;
         err_m <= err_m_n;
         rd_m  <= rd_m_n;
         grant <= grant_n;
         req   <= req_n;
         we    <= we_n;
         addr  <= addr_n;
         wd    <= wd_n;
      end
   end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: directed stimulus with a queue-based scoreboard.
// Masters and slave are small processes; a monitor checks each completion.
module tb_bus_rr_arbiter;

   localparam int M = 2;
   localparam int T = 4;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [M-1:0]  req_m = '0;
   logic [M-1:0]  we_m = '0;
   logic [M*32-1:0] addr_m = '0;
   logic [M*32-1:0] wd_m = '0;
   logic [M-1:0]  ack_m;
   logic [M-1:0]  err_m;
   logic [31:0]   rd_m;
   logic [M-1:0]  grant;
   logic          req;
   logic          we;
   logic [31:0]   addr;
   logic [31:0]   wd;
   logic          ack = 1'b0;
   logic [31:0]   rd = '0;

   always #5 clk = ~clk;

   bus_rr_arbiter #(.mst_c(M), .tmo_c(T)) dut (
      .clk    (clk),
      .resetn (resetn),
      .req_m  (req_m),
      .we_m   (we_m),
      .addr_m (addr_m),
      .wd_m   (wd_m),
      .ack_m  (ack_m),
      .err_m  (err_m),
      .rd_m   (rd_m),
      .grant  (grant),
      .req    (req),
      .we     (we),
      .addr   (addr),
      .wd     (wd),
      .ack    (ack),
      .rd     (rd)
   );

   typedef struct {
      int          mst;
      bit          is_err;
      logic [31:0] rdv;
      bit          wev;
      logic [31:0] av;
      logic [31:0] dv;
      int          len;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   int          rem[M] = '{0, 0};
   int          ack_dly = -1;
   logic [31:0] slv_rd = '0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_txn(input int mst, input bit is_err,
                             input logic [31:0] rdv, input bit wev,
                             input logic [31:0] av, input logic [31:0] dv,
                             input int len);
      exp_t e;
      e.mst = mst;
      e.is_err = is_err;
      e.rdv = rdv;
      e.wev = wev;
      e.av = av;
      e.dv = dv;
      e.len = len;
      q.push_back(e);
   endtask

   task automatic set_mst(input int i, input bit w,
                          input logic [31:0] a, input logic [31:0] d);
      we_m[i] = w;
      addr_m[i*32 +: 32] = a;
      wd_m[i*32 +: 32] = d;
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while ((q.size() != 0 || rem[0] != 0 || rem[1] != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (q.size() != 0 || rem[0] != 0 || rem[1] != 0) begin
         errors++;
         $display("FAIL %s: timed out with %0d pending, expected 0",
                  name, q.size());
         q.delete();
         rem[0] = 0;
         rem[1] = 0;
      end
      repeat (2) @(negedge clk);
   endtask

   // Masters: hold req_m while work remains, drop it when the pulse is seen.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         for (int i = 0; i < M; i++) begin
            if (ack_m[i] || err_m[i]) begin
               req_m[i] = 1'b0;
               if (rem[i] > 0) rem[i]--;
            end else begin
               req_m[i] = (rem[i] > 0);
            end
         end
      end
   end

   // Slave: ack after ack_dly BUSY cycles, never when ack_dly is negative.
   initial begin
      int bcnt = 0;
      forever begin
         @(negedge clk);
         if (req) begin
            ack = (ack_dly >= 0) && (bcnt == ack_dly);
            rd = ack ? slv_rd : 32'h0BAD_0BAD;
            bcnt++;
         end else begin
            ack = 1'b0;
            rd = 32'h0BAD_0BAD;
            bcnt = 0;
         end
      end
   end

   // Monitor: checks the slave side at request start and each completion.
   initial begin
      exp_t       e;
      bit         prev = 1'b0;
      int         rlen = 0;
      logic       req_q = 1'b0;
      logic [1:0] oh;
      forever begin
         @(negedge clk);
         #1;
         if (!resetn) begin
            prev = 1'b0;
            rlen = 0;
            req_q = 1'b0;
         end else begin
            if (req && !req_q) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_req: got grant %b, expected no request",
                           grant);
               end else begin
                  e = q[0];
                  oh = 2'b01 << e.mst;
                  chk("grant_at_req", grant, oh);
                  chk("slave_addr", addr, e.av);
                  chk("slave_we", we, e.wev);
                  chk("slave_wd", wd, e.dv);
               end
            end
            if (req) rlen++;
            if ((ack_m | err_m) != '0) begin
               chk("ack_err_excl", (ack_m != 0) && (err_m != 0), 0);
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_pulse: got ack %b err %b, expected none",
                           ack_m, err_m);
               end else begin
                  e = q.pop_front();
                  oh = 2'b01 << e.mst;
                  chk("pulse_owner", ack_m | err_m, oh);
                  chk("pulse_grant", grant, oh);
                  chk("pulse_is_err", err_m != 0, e.is_err);
                  chk("rd_m", rd_m, e.rdv);
                  if (e.len >= 0) chk("req_len", rlen, e.len);
               end
               rlen = 0;
               prev = 1'b1;
            end else begin
               if (prev) begin
                  chk("grant_release", grant, 0);
                  prev = 1'b0;
               end
               if (!req) rlen = 0;
            end
            req_q = req;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req", {req, we}, 0);
      chk("rst_grant", grant, 0);
      chk("rst_pulses", {ack_m, err_m}, 0);
      chk("rst_rd_m", rd_m, 0);
      chk("rst_addr_wd", {addr, wd}, 0);
      resetn = 1'b1;

      // single write from m0, ack on third BUSY cycle
      set_mst(0, 1'b1, 32'h0000_1000, 32'hA5A5_A5A5);
      ack_dly = 2;
      slv_rd = 32'h0;
      expect_txn(0, 1'b0, 32'h0, 1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 3);
      rem[0] = 1;
      n = 0;
      while (!req_m[0] && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("latency_before", req, 0);
      @(negedge clk);
      chk("latency_after", req, 1);
      drain("t1_write", 50);

      // reset, then both masters stream: grants alternate from m0
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      set_mst(0, 1'b0, 32'h0000_0100, 32'h0000_0011);
      set_mst(1, 1'b1, 32'h0000_0200, 32'h0000_0022);
      ack_dly = 0;
      slv_rd = 32'h1234_5678;
      expect_txn(0, 1'b0, 32'h1234_5678, 1'b0, 32'h0000_0100, 32'h0000_0011, 1);
      expect_txn(1, 1'b0, 32'h1234_5678, 1'b1, 32'h0000_0200, 32'h0000_0022, 1);
      expect_txn(0, 1'b0, 32'h1234_5678, 1'b0, 32'h0000_0100, 32'h0000_0011, 1);
      expect_txn(1, 1'b0, 32'h1234_5678, 1'b1, 32'h0000_0200, 32'h0000_0022, 1);
      rem[0] = 2;
      rem[1] = 2;
      drain("t2_alternate", 100);

      // m1 read returns DEAD_BEEF, which rd_m keeps afterwards
      set_mst(1, 1'b0, 32'h0000_2004, 32'h0000_0022);
      ack_dly = 1;
      slv_rd = 32'hDEAD_BEEF;
      expect_txn(1, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0000_2004, 32'h0000_0022, 2);
      rem[1] = 1;
      drain("t3_read", 50);
      repeat (3) @(negedge clk);
      chk("rd_m_hold", rd_m, 32'hDEAD_BEEF);

      // dead slave: m0 times out after 4 BUSY cycles, then m1 is served
      set_mst(0, 1'b0, 32'h0000_3000, 32'h0000_0033);
      ack_dly = -1;
      expect_txn(0, 1'b1, 32'h0, 1'b0, 32'h0000_3000, 32'h0000_0033, 4);
      rem[0] = 1;
      drain("t4_timeout", 50);
      set_mst(1, 1'b1, 32'h0000_4000, 32'h0000_0077);
      ack_dly = 0;
      slv_rd = 32'h0000_5555;
      expect_txn(1, 1'b0, 32'h0000_5555, 1'b1, 32'h0000_4000, 32'h0000_0077, 1);
      rem[1] = 1;
      drain("t4_after", 50);

      // ack lands on the timeout cycle: ack wins
      set_mst(0, 1'b0, 32'h0000_5000, 32'h0000_0055);
      ack_dly = 3;
      slv_rd = 32'hC0FF_EE00;
      expect_txn(0, 1'b0, 32'hC0FF_EE00, 1'b0, 32'h0000_5000, 32'h0000_0055, 4);
      rem[0] = 1;
      drain("t5_coincident", 50);

      // reset mid-transaction abandons it; m0 wins first afterwards
      set_mst(0, 1'b0, 32'h0000_6000, 32'h0000_0066);
      ack_dly = -1;
      expect_txn(0, 1'b1, 32'h0, 1'b0, 32'h0000_6000, 32'h0000_0066, -1);
      rem[0] = 1;
      n = 0;
      while (!req && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("t6_busy", req, 1);
      resetn = 1'b0;
      rem[0] = 0;
      rem[1] = 0;
      q.delete();
      @(negedge clk);
      resetn = 1'b1;
      chk("t6_rst_req", req, 0);
      chk("t6_rst_grant", grant, 0);
      chk("t6_rst_pulses", {ack_m, err_m}, 0);
      set_mst(1, 1'b1, 32'h0000_7000, 32'h0000_0088);
      ack_dly = 0;
      slv_rd = 32'h0000_0101;
      expect_txn(0, 1'b0, 32'h0000_0101, 1'b0, 32'h0000_6000, 32'h0000_0066, 1);
      expect_txn(1, 1'b0, 32'h0000_0101, 1'b1, 32'h0000_7000, 32'h0000_0088, 1);
      rem[0] = 1;
      rem[1] = 1;
      drain("t6_after", 50);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
